// File: rtl/mem_access_initiator.sv
// Frost32 load/store engine: turns one CPU memory command into word read/write beats (RMW for sub-word stores).
// Optional read-beat timeout is enabled by defining OPT_MEM_ACCESS_TIMEOUT_EN.
module mem_access_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_start,
    input  logic        in_is_store,
    input  logic [1:0]  in_size,
    input  logic        in_sign_ext,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        out_busy,
    output logic        out_done,
    output logic [31:0] out_rdata,
    output logic        out_misaligned,
    output logic        out_timeout,
    output logic        out_req_mem_access,
    output logic        out_data_inout_access_type,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    input  logic [31:0] in_mem_data,
    input  logic        in_wait_for_mem
);
    localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  off_q, off_d, size_q, size_d;
    logic        store_q, store_d, sext_q, sext_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
    logic        type_q, type_d, done_q, done_d, mis_q, mis_d, tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        if (sz[1])      return off != 2'b00;
        else if (sz[0]) return off[0];
        else            return 1'b0;
    endfunction

    // Big-endian lanes: byte offset 0 is the most significant byte.
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] r;
        r = w;
        if (sz[1]) begin
            r = wd;
        end else if (sz[0]) begin
            if (off[1]) r[15:0] = wd[15:0];
            else        r[31:16] = wd[15:0];
        end else begin
            case (off)
                2'd0:    r[31:24] = wd[7:0];
                2'd1:    r[23:16] = wd[7:0];
                2'd2:    r[15:8]  = wd[7:0];
                default: r[7:0]   = wd[7:0];
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        if (sz[1])      return w;
        else if (sz[0]) return {{16{sx & h[15]}}, h};
        else            return {{24{sx & b[7]}}, b};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            off_q   <= '0;
            size_q  <= '0;
            store_q <= 1'b0;
            sext_q  <= 1'b0;
            wdata_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            type_q  <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            size_q  <= size_d;
            store_q <= store_d;
            sext_q  <= sext_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            type_q  <= type_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        size_d  = size_q;
        store_d = store_q;
        sext_d  = sext_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        mis_d   = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    off_d   = in_addr[1:0];
                    size_d  = in_size;
                    store_d = in_is_store;
                    sext_d  = in_sign_ext;
                    wdata_d = in_wdata;
                    if (is_misaligned(in_size, in_addr[1:0])) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        addr_d = {in_addr[31:2], 2'b00};
                        if (in_is_store && in_size[1]) begin
                            state_d = S_WR;
                            type_d  = 1'b1;
                            data_d  = in_wdata;
                        end else begin
                            state_d = S_RD;
                            type_d  = 1'b0;
                            cnt_d   = '0;
                        end
                    end
                end
            end
            S_RD: begin
                if (!in_wait_for_mem) begin
                    if (store_q) begin
                        state_d = S_WR;
                        type_d  = 1'b1;
                        data_d  = merge(in_mem_data, wdata_q, size_q, off_q);
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        rdata_d = extract(in_mem_data, size_q, off_q, sext_q);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
`ifdef OPT_MEM_ACCESS_TIMEOUT_EN
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        tmo_d   = 1'b1;
                        rdata_d = '0;
                    end
`endif
                end
            end
            S_WR: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                rdata_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request and busy come straight from state so an async reset drops them at once.
    always_comb begin
        out_busy           = (state_q != S_IDLE);
        out_req_mem_access = (state_q == S_RD) || (state_q == S_WR);
    end

    assign out_done                   = done_q;
    assign out_rdata                  = rdata_q;
    assign out_misaligned             = mis_q;
    assign out_timeout                = tmo_q;
    assign out_data_inout_access_type = type_q;
    assign out_addr                   = addr_q;
    assign out_data                   = data_q;

endmodule

// File: doc/mem_access_initiator.md
# mem_access_initiator

Requester-side engine for the Frost32 main memory port. Accepts one load/store command at a time from the CPU pipeline and converts it into word-sized read/write beats on the main-memory request interface. Sub-word stores become a read-modify-write sequence, and load results are returned extracted and sign- or zero-extended. It sits between the CPU's execute/memory stage and the main memory block.

## Interface
- `TIMEOUT_CYCLES`, default 255: read-beat wait limit; only used with `OPT_MEM_ACCESS_TIMEOUT_EN`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_start` in 1: command strobe, sampled only when `out_busy`=0.
- `in_is_store` in 1: 1 = store, 0 = load.
- `in_size` in 2: 0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- `in_sign_ext` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `in_addr` in 32: byte address.
- `in_wdata` in 32: store data, right-justified for sub-word sizes.
- `out_busy` out 1: command in flight.
- `out_done` out 1: one-cycle completion pulse.
- `out_rdata` out 32: load result; valid while `out_done`=1, held until the next accepted command.
- `out_misaligned` out 1: pulses with `out_done` for a misaligned command.
- `out_timeout` out 1: pulses with `out_done` on a read timeout.
- `out_req_mem_access` out 1: memory request.
- `out_data_inout_access_type` out 1: 0 = read (`DiatRead`), 1 = write (`DiatWrite`).
- `out_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `out_data` out 32: write data.
- `in_mem_data` in 32: read data from memory, combinational to `out_addr`.
- `in_wait_for_mem` in 1: memory stall.

## Operation
- FSM states: IDLE, RD, WR, DONE.
- IDLE, when `in_start`=1:
  - Register addr, size, store flag, sign-ext flag and wdata.
  - Misaligned command (half with `addr[0]`=1, or word with `addr[1:0]`≠0): go to DONE with misaligned flag set; no memory beat is issued.
  - Load or sub-word store: go to RD.
  - Word store: go to WR.
- `in_start` while busy is ignored.
- RD:
  - Drive req=1, type=0.
  - The beat completes on the first edge where `in_wait_for_mem`=0; `in_mem_data` is captured into the word register on that edge.
  - Next state is WR for a store, DONE for a load.
- WR:
  - Drive req=1, type=1, `out_data` = merged word.
  - The write commits on the first edge in WR; `in_wait_for_mem` is ignored for writes. Next state is DONE.
- DONE: assert `out_done` and update `out_rdata` (registered, same cycle as `out_done`), then go to IDLE.
- Byte lanes are big-endian. Byte offset o occupies `word[31-8o -: 8]`; half offset 0 is `[31:16]`, offset 2 is `[15:0]`.
- Merge replaces only the addressed lane with the low bits of wdata. A word store sends wdata unchanged.
- Load extract: take the lane, then sign-extend from its MSB when sign_ext=1, otherwise zero-fill. Word loads ignore sign_ext.
- Misaligned or timed-out commands return `out_rdata`=0.
- In IDLE and DONE: req=0, and `out_addr`/`out_data`/type hold their last values.

## Timing
- Reset values (async): state IDLE; `out_busy`, `out_done`, `out_misaligned`, `out_timeout`, `out_req_mem_access` and `out_data_inout_access_type` = 0; `out_addr`, `out_data` and `out_rdata` = 0.
- `out_busy` = (state ≠ IDLE), combinational from state.
- Latency from the accepting edge to `out_done` high, with no wait:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Misaligned: 1 cycle.
  - Each cycle of `in_wait_for_mem`=1 in RD adds one cycle.
- Back-to-back: a new `in_start` is accepted in the cycle after DONE, so the minimum period is 3 cycles per load.
- Reset asserted mid-command aborts immediately: req drops asynchronously and no `out_done` is produced.

## Configuration
- `OPT_MEM_ACCESS_TIMEOUT_EN` defined:
  - An 8+-bit counter (width sized for `TIMEOUT_CYCLES`) counts consecutive RD cycles with `in_wait_for_mem`=1.
  - When it reaches `TIMEOUT_CYCLES`, go to DONE with `out_timeout`=1 and `out_rdata`=0.
  - A store aborted this way issues no WR beat.
  - The counter clears on entry to RD.
- Not defined: RD waits indefinitely, and `out_timeout` is tied to 0.

## Test plan
- Load word at 0x100, memory returns 0xDEADBEEF, no wait -> `out_done` 2 cycles after start, `out_rdata`=0xDEADBEEF, one read beat with `out_addr`=0x100.
- Load byte at 0x103 with sign_ext=1, word 0x123456F0 -> `out_rdata`=0xFFFFFFF0; same with sign_ext=0 -> 0x000000F0.
- Store half 0xABCD at 0x202, existing word 0x11223344 -> read beat, then write beat `out_data`=0x1122ABCD; done 3 cycles after start.
- Load half at 0x101 -> `out_misaligned`=1 and `out_done`=1 one cycle after start, no `out_req_mem_access` pulse, `out_rdata`=0.
- Load word with `in_wait_for_mem` high 4 cycles -> done at cycle 6; second `in_start` during busy is ignored; with the macro defined and `TIMEOUT_CYCLES`=3 -> `out_timeout` pulse, `out_rdata`=0.
- Assert `rst` in the RD state -> `out_req_mem_access` drops in the same cycle, no `out_done`; after release a fresh load completes normally.
